// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, R/W bit and ACK/NACK line levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } i2c_state_t;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

    // Open-drain: a 0 on the line means pull low, a 1 means release.
    function automatic logic drive_for(input logic level);
        return ~level;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into clk and detects SCL edges plus START/STOP conditions.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_d;
    logic       r_sda_d;
    logic       w_scl_s;

    // Reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl};
            r_sda_sync <= {r_sda_sync[0], sda_in};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl_s   = r_scl_sync[1];
    assign sda_s     = r_sda_sync[1];
    assign scl_rise  =  w_scl_s & ~r_scl_d;
    assign scl_fall  = ~w_scl_s &  r_scl_d;
    assign start_det =  w_scl_s &  r_scl_d &  r_sda_d & ~sda_s;
    assign stop_det  =  w_scl_s &  r_scl_d & ~r_sda_d &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with pointer-addressed register file; define I2C_AUTOINC_EN for
// pointer auto-increment after each written byte and each ACKed read byte.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         NREG     = 16,
    parameter int         HOLD     = 5,
    localparam int        PTR_W    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda_in,
    output logic             sda_out,
    output logic             sda_en,
    output logic             busy,
    output logic             wr_stb,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data
);

    localparam int HOLD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
`ifdef I2C_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    i2c_bus_sync u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    i2c_state_t       r_state, w_next_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_rw;
    logic             r_mack;
    logic [PTR_W-1:0] r_ptr;
    logic             r_ptr_set;
    logic [7:0]       r_regs [NREG];
    logic             r_sda_en;
    logic             r_pend_en;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic             r_busy;
    logic             r_wr_stb;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    logic             w_abort, w_sched, w_sched_val;
    logic             w_load_ptr, w_do_write, w_load_rd, w_ptr_inc;
    logic             w_busy_set, w_busy_clr;
    logic [7:0]       w_shift_in;
    logic [7:0]       w_rd_byte;
    logic [PTR_W-1:0] w_ptr_next;

    assign w_shift_in = {r_shift[6:0], w_sda_s};
    assign w_rd_byte  = r_regs[r_ptr];
    assign w_ptr_next = (r_ptr == PTR_W'(NREG - 1)) ? '0 : r_ptr + 1'b1;
    assign w_abort    = w_start_det | w_stop_det;

    // NOTE: sequential state uses non-blocking assignments only; the
    // combinational block below uses blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_sched      = 1'b0;
        w_sched_val  = 1'b0;
        w_load_ptr   = 1'b0;
        w_do_write   = 1'b0;
        w_load_rd    = 1'b0;
        w_ptr_inc    = 1'b0;
        w_busy_set   = 1'b0;
        w_busy_clr   = 1'b0;
        if (w_start_det) begin
            w_next_state = ST_ADDR;
        end else if (w_stop_det) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR: if (w_scl_rise && r_bit_cnt == 4'd7) begin
                    if (w_shift_in[7:1] == DEV_ADDR) begin
                        w_next_state = ST_ADDR_ACK;
                        w_busy_set   = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_busy_clr   = 1'b1;
                    end
                end
                ST_ADDR_ACK: if (w_scl_fall) begin
                    w_sched = 1'b1;
                    if (r_bit_cnt == 4'd8) begin
                        w_sched_val = drive_for(ACK);
                    end else if (r_rw == I2C_RD) begin
                        // Releasing the ACK and presenting the first data bit coincide.
                        w_load_rd    = 1'b1;
                        w_sched_val  = drive_for(w_rd_byte[7]);
                        w_next_state = ST_RDATA;
                    end else begin
                        w_next_state = r_ptr_set ? ST_WDATA : ST_PTR;
                    end
                end
                ST_PTR: if (w_scl_rise && r_bit_cnt == 4'd7) begin
                    if (32'(w_shift_in) >= NREG) begin
                        w_next_state = ST_IDLE;
                        w_busy_clr   = 1'b1;
                    end else begin
                        w_load_ptr   = 1'b1;
                        w_next_state = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
                    w_sched = 1'b1;
                    if (r_bit_cnt == 4'd8) w_sched_val  = drive_for(ACK);
                    else                   w_next_state = ST_WDATA;
                end
                ST_WDATA: if (w_scl_rise && r_bit_cnt == 4'd7) begin
                    w_do_write   = 1'b1;
                    w_ptr_inc    = AUTOINC;
                    w_next_state = ST_WDATA_ACK;
                end
                ST_RDATA: if (w_scl_fall) begin
                    w_sched = 1'b1;
                    if (r_bit_cnt == 4'd8) w_next_state = ST_RACK;
                    else                   w_sched_val  = drive_for(r_shift[6]);
                end
                ST_RACK: begin
                    if (w_scl_rise && w_sda_s == ACK) w_ptr_inc = AUTOINC;
                    if (w_scl_fall && r_bit_cnt == 4'd9) begin
                        w_sched = 1'b1;
                        if (r_mack == ACK) begin
                            w_load_rd    = 1'b1;
                            w_sched_val  = drive_for(w_rd_byte[7]);
                            w_next_state = ST_RDATA;
                        end else begin
                            w_next_state = ST_IDLE;
                            w_busy_clr   = 1'b1;
                        end
                    end
                end
                ST_IDLE: ;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // Bit counter runs 1..8 over data bits and reaches 9 on the ACK clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rw      <= I2C_WR;
            r_mack    <= NACK;
        end else if (w_abort) begin
            r_bit_cnt <= '0;
        end else begin
            if (w_scl_rise && r_state != ST_IDLE)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            else if (w_scl_fall && r_bit_cnt == 4'd9)
                r_bit_cnt <= '0;

            if (w_load_rd)
                r_shift <= w_rd_byte;
            else if (w_scl_rise && r_state inside {ST_ADDR, ST_PTR, ST_WDATA})
                r_shift <= w_shift_in;
            else if (w_scl_fall && r_state == ST_RDATA && r_bit_cnt != 4'd8)
                r_shift <= {r_shift[6:0], 1'b0};

            if (w_scl_rise && r_state == ST_ADDR && r_bit_cnt == 4'd7) r_rw   <= w_sda_s;
            if (w_scl_rise && r_state == ST_RACK)                      r_mack <= w_sda_s;
        end
    end

    // SDA changes only HOLD clocks after the SCL fall that scheduled it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sda_en   <= 1'b0;
            r_pend_en  <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_abort) begin
            r_sda_en   <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_sched) begin
            r_pend_en <= w_sched_val;
            if (HOLD == 0) r_sda_en   <= w_sched_val;
            else           r_hold_cnt <= HOLD_W'(HOLD);
        end else if (r_hold_cnt == HOLD_W'(1)) begin
            r_sda_en   <= r_pend_en;
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file has a defined reset value, so it is
            // cleared here rather than left as uninitialised memory.
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_ptr     <= '0;
            r_ptr_set <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_wr_stb <= w_do_write;
            if (w_do_write) begin
                r_regs[r_ptr] <= w_shift_in;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_shift_in;
            end

            if (w_load_ptr)     r_ptr <= PTR_W'(w_shift_in);
            else if (w_ptr_inc) r_ptr <= w_ptr_next;

            // The pointer stays valid across a repeated START until STOP.
            if (w_stop_det)      r_ptr_set <= 1'b0;
            else if (w_load_ptr) r_ptr_set <= 1'b1;

            if (w_stop_det || w_busy_clr) r_busy <= 1'b0;
            else if (w_busy_set)          r_busy <= 1'b1;
        end
    end

    assign sda_en  = r_sda_en;
    assign sda_out = ~r_sda_en;
    assign busy    = r_busy;
    assign wr_stb  = r_wr_stb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on a wired-AND SDA line.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 20;  // clk cycles per quarter SCL period

`ifdef I2C_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_out, sda_en, busy, wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    wire        sda_line = m_sda & (sda_en ? sda_out : 1'b1);

    int n_checks = 0;
    int n_errors = 0;

    int         wr_cnt  = 0;
    int         en_cnt  = 0;
    int         busy_cnt = 0;
    int         bad_drive = 0;
    logic [3:0] log_addr [64];
    logic [7:0] log_data [64];

    i2c_target dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (m_scl),
        .sda_in  (sda_line),
        .sda_out (sda_out),
        .sda_en  (sda_en),
        .busy    (busy),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb) begin
            if (wr_cnt < 64) begin
                log_addr[wr_cnt] = wr_addr;
                log_data[wr_cnt] = wr_data;
            end
            wr_cnt++;
        end
        if (sda_en)           en_cnt++;
        if (busy)             busy_cnt++;
        if (sda_en && sda_out) bad_drive++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b0; quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; quarter();
        m_scl = 1'b1; quarter();
        m_sda = 1'b1; quarter();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; quarter();
            m_scl = 1'b1; quarter(); quarter();
            m_scl = 1'b0; quarter();
        end
        m_sda = 1'b1; quarter();
        m_scl = 1'b1; quarter();
        ack = sda_line; quarter();
        m_scl = 1'b0; quarter();
    endtask

    task automatic recv_byte(input logic ack_bit, output logic [7:0] b, output logic en_at_ack);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            quarter();
            m_scl = 1'b1; quarter();
            b[i] = sda_line; quarter();
            m_scl = 1'b0; quarter();
        end
        m_sda = ack_bit; quarter();
        m_scl = 1'b1; quarter();
        en_at_ack = sda_en; quarter();
        m_scl = 1'b0; quarter();
        m_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic       en_ack;
        logic [7:0] rd;
        int         wr0, en0, busy0;

        repeat (5) @(negedge clk);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_sda_en",  sda_en,  1'b0);
        check("rst_busy",    busy,    1'b0);
        check("rst_wr_stb",  wr_stb,  1'b0);
        check("rst_wr_addr", wr_addr, 4'h0);
        check("rst_wr_data", wr_data, 8'h00);
        rst = 1'b0;
        quarter();

        // Write 0xA5 to register 3.
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t1_addr_ack", ack, ACK);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h03, ack); check("t1_ptr_ack", ack, ACK);
        send_byte(8'hA5, ack); check("t1_data_ack", ack, ACK);
        bus_stop(); quarter();
        check("t1_busy_after_stop", busy, 1'b0);
        check("t1_wr_count", wr_cnt - wr0, 1);
        check("t1_wr_addr", log_addr[wr0], 4'h3);
        check("t1_wr_data", log_data[wr0], 8'hA5);

        // Combined read with repeated START, single byte then NACK.
        bus_start();
        send_byte(8'hA0, ack); check("t2_addr_ack", ack, ACK);
        send_byte(8'h03, ack); check("t2_ptr_ack", ack, ACK);
        bus_start();
        send_byte(8'hA1, ack); check("t2_raddr_ack", ack, ACK);
        recv_byte(NACK, rd, en_ack);
        check("t2_rdata", rd, 8'hA5);
        check("t2_release_9th", en_ack, 1'b0);
        bus_stop(); quarter();
        check("t2_busy_after_stop", busy, 1'b0);

        // Address mismatch: 0x51.
        wr0 = wr_cnt; en0 = en_cnt; busy0 = busy_cnt;
        bus_start();
        send_byte(8'hA2, ack); check("t3_addr_nack", ack, NACK);
        send_byte(8'h03, ack); check("t3_next_nack", ack, NACK);
        bus_stop(); quarter();
        check("t3_no_drive", en_cnt - en0, 0);
        check("t3_no_busy", busy_cnt - busy0, 0);
        check("t3_no_write", wr_cnt - wr0, 0);

        // Out-of-range pointer is refused and leaves the pointer at 3.
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("t4_addr_ack", ack, ACK);
        send_byte(8'h20, ack); check("t4_ptr_nack", ack, NACK);
        check("t4_busy_cleared", busy, 1'b0);
        bus_stop(); quarter();
        check("t4_no_write", wr_cnt - wr0, 0);
        bus_start();
        send_byte(8'hA1, ack); check("t4_raddr_ack", ack, ACK);
        recv_byte(NACK, rd, en_ack);
        check("t4_ptr_kept", rd, 8'hA5);
        bus_stop(); quarter();

        // Two-byte read: controller ACKs the first byte.
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        bus_start();
        send_byte(8'hA1, ack); check("t2b_raddr_ack", ack, ACK);
        recv_byte(ACK, rd, en_ack);
        check("t2b_byte0", rd, 8'hA5);
        recv_byte(NACK, rd, en_ack);
        check("t2b_byte1", rd, AUTOINC ? 8'h00 : 8'hA5);
        bus_stop(); quarter();

        // Reset while the target pulls SDA low for bit 6 of 0xA5.
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        bus_start();
        send_byte(8'hA1, ack); check("t5_raddr_ack", ack, ACK);
        quarter();
        m_scl = 1'b1; quarter(); quarter();
        m_scl = 1'b0; quarter();
        check("t5_driving_zero", sda_en, 1'b1);
        rst = 1'b1;
        #1;
        check("t5_async_release", sda_en, 1'b0);
        check("t5_busy_reset", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quarter();
        bus_start();
        send_byte(8'hA1, ack); check("t5_post_addr_ack", ack, ACK);
        recv_byte(NACK, rd, en_ack);
        check("t5_regs_cleared", rd, 8'h00);
        bus_stop(); quarter();

        // Two writes starting at the last register.
        wr0 = wr_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack); check("t6_ptr_ack", ack, ACK);
        send_byte(8'h11, ack); check("t6_d0_ack", ack, ACK);
        send_byte(8'h22, ack); check("t6_d1_ack", ack, ACK);
        bus_stop(); quarter();
        check("t6_wr_count", wr_cnt - wr0, 2);
        check("t6_wr0_addr", log_addr[wr0], 4'hF);
        check("t6_wr0_data", log_data[wr0], 8'h11);
        check("t6_wr1_addr", log_addr[wr0 + 1], AUTOINC ? 4'h0 : 4'hF);
        check("t6_wr1_data", log_data[wr0 + 1], 8'h22);
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        bus_start();
        send_byte(8'hA1, ack);
        recv_byte(NACK, rd, en_ack);
        check("t6_reg15", rd, AUTOINC ? 8'h11 : 8'h22);
        bus_stop(); quarter();
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        bus_start();
        send_byte(8'hA1, ack);
        recv_byte(NACK, rd, en_ack);
        check("t6_reg0", rd, AUTOINC ? 8'h22 : 8'h00);
        bus_stop(); quarter();

        check("end_sda_en", sda_en, 1'b0);
        check("open_drain_level", bad_drive, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
